mem_arbiter: RTL
================

# mem_arbiter

Shares the CPU's single-port RAM between two requesters: the instruction-fetch path (F) and the load/store data path (D). Each access is a req/done handshake with one transaction in flight. The arbiter registers the RAM address, write data and write enable, waits the RAM read latency, and returns read data to the owner. This replaces the fixed pc/alu_result address select in the core sequencer, so fetch and memory stages may request independently.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LATENCY, 2, edges from ram_addr presented to ram_rdata valid; legal range 1..15

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request; held until f_done
- f_addr  in  ADDR_W  fetch address; stable while f_req
- f_done  out  1  one-cycle completion pulse to fetch
- f_rdata  out  DATA_W  fetch read data; valid while f_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle completion pulse to data
- d_rdata  out  DATA_W  load data; valid while d_done
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_wren  out  1  RAM write enable, registered
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  transaction in progress; high in states other than IDLE

## Operation
- States are IDLE, WAIT and RESP. Internal registers are owner (F/D), last_owner (F/D) and a 4-bit cnt.
- Arbitration runs only in IDLE at a rising edge:
  - If only one req is high, that requester is granted.
  - If both are high, the requester that is not last_owner is granted, so F and D alternate.
  - If neither is high, the arbiter stays in IDLE.
- Grant edge (E0):
  - owner and last_owner are set to the granted requester.
  - ram_addr and ram_wdata are loaded. Fetch loads ram_wdata with 0.
  - ram_wren is loaded with d_we for D and with 0 for F.
  - cnt is loaded with RD_LATENCY for a read and 1 for a write.
  - State goes to WAIT.
- WAIT:
  - ram_wren is cleared at the first edge.
  - cnt decrements each edge.
  - At the edge where cnt==1, state goes to RESP and the owner's done is set. For a read, that edge also samples ram_rdata into the owner's rdata register.
- RESP:
  - The done pulse is high for this cycle only.
  - At the next edge, done clears and state goes to IDLE. req is ignored in RESP.
  - The requester drops or renews req during this cycle.
- ram_addr and ram_wdata hold their values from E0 until the next grant. They are not cleared in IDLE.
- f_rdata and d_rdata hold their last value until that port's next read completes.
- The non-owner's done and rdata are never disturbed.
- If req is withdrawn mid-transaction, the transaction still completes and done still pulses. Requesters must not do this.
- If req changes in WAIT or RESP, the change has no effect on the current transaction.

## Timing
- Reset values: all outputs are 0, state=IDLE, cnt=0, owner=F, last_owner=F. With these values D wins the first contended grant.
- Reset asserted mid-transaction aborts it immediately: no done pulse, ram_wren drops asynchronously. After release, arbitration resumes at the first rising edge.
- Read: ram_addr is valid after E0. Done is high in the cycle after edge E0+RD_LATENCY.
- Write: ram_wren is high for exactly the cycle after E0. Done is high in the cycle after E0+1.
- Back-to-back: the earliest next grant edge is E0+N+2, where N is RD_LATENCY for a read and 1 for a write. Read throughput is one access per RD_LATENCY+2 cycles.
- Handshake: req high is sampled in IDLE. Done is a one-cycle pulse. The requester samples rdata in the same cycle as done.

## Test plan
- F-only read, RD_LATENCY=2: f_req, f_addr=0x100; model RAM returns 0xDEADBEEF two edges after the address. Required: f_done high for exactly one cycle, 3 cycles after the req edge; f_rdata=0xDEADBEEF; d_done stays 0.
- D write: d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678. Required: ram_wren high for one cycle with ram_addr=0x200 and ram_wdata=0x12345678; d_done follows one cycle later; ram_wren never asserts on an F access.
- Contention from reset: f_req and d_req held high continuously. Required: grants go D, F, D, F; each done is a single pulse; grant edges are RD_LATENCY+2 apart.
- Sustained F with one D request: f_req always high, d_req rises once. Required: D is granted at the next IDLE edge after the current F access finishes; F resumes afterwards.
- Reset mid-read: assert reset in WAIT. Required: all outputs read 0 immediately, including ram_wren; no done pulse appears; a fresh f_req after release completes normally.
- RD_LATENCY=1 and RD_LATENCY=15 reads. Required: done-cycle offset equals RD_LATENCY+1 in both cases.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port RAM between fetch (F) and data (D).
// One transaction in flight; F and D alternate under contention, read data returned after RD_LATENCY.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_done,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   // state | meaning
   // IDLE  | arbitrate between f_req and d_req
   // WAIT  | RAM access in flight, cnt counts down to the sample edge
   // RESP  | owner's done pulse is high for this one cycle
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic       OWN_F  = 1'b0;
   localparam logic       OWN_D  = 1'b1;
   localparam logic [3:0] RD_CNT = 4'(RD_LATENCY);

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              wr_q, wr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_wren_q, ram_wren_d;
   logic              f_done_q, f_done_d;
   logic              d_done_q, d_done_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_d;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_wren_d   = ram_wren_q;
      f_done_d     = f_done_q;
      d_done_d     = d_done_q;
      f_rdata_d    = f_rdata_q;
      d_rdata_d    = d_rdata_q;
      grant_d      = OWN_F;

      case (state_q)
         S_IDLE: begin
            if (f_req || d_req) begin
               // Under contention the side that did not own the last access wins.
               grant_d      = (f_req && d_req) ? ~last_owner_q : d_req;
               owner_d      = grant_d;
               last_owner_d = grant_d;
               wr_d         = grant_d & d_we;
               ram_addr_d   = (grant_d == OWN_D) ? d_addr : f_addr;
               ram_wdata_d  = (grant_d == OWN_D) ? d_wdata : '0;
               ram_wren_d   = grant_d & d_we;
               cnt_d        = (grant_d & d_we) ? 4'd1 : RD_CNT;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            ram_wren_d = 1'b0;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               if (owner_q == OWN_D) begin
                  d_done_d = 1'b1;
                  if (!wr_q) d_rdata_d = ram_rdata;
               end else begin
                  f_done_d  = 1'b1;
                  f_rdata_d = ram_rdata;
               end
            end
         end
         S_RESP: begin
            f_done_d = 1'b0;
            d_done_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_F;
         last_owner_q <= OWN_F;
         wr_q         <= 1'b0;
         cnt_q        <= 4'd0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_wren_q   <= 1'b0;
         f_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         f_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_wren_q   <= ram_wren_d;
         f_done_q     <= f_done_d;
         d_done_q     <= d_done_d;
         f_rdata_q    <= f_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign f_done    = f_done_q;
   assign d_done    = d_done_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_wren  = ram_wren_q;
   assign busy      = (state_q != S_IDLE);

endmodule
